// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, opcode encodings and sequencer states for the execute/writeback block
package cpu_pkg;
  localparam int DATA_W = 8;
  localparam int AREG_W = 3;
  localparam int NREG = 8;
  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR = 3'd3;
  localparam logic [2:0] OP_NOT = 3'd4;
  localparam logic [2:0] OP_XOR = 3'd5;
  localparam logic [2:0] OP_LOADI = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_e;
endpackage

// File: rtl/alu_exec_ctrl_if.sv
// alu_exec_ctrl_if: instruction handshake, ALU drive/return and retire status
interface alu_exec_ctrl_if;
  import cpu_pkg::*;
  logic instr_valid;
  logic instr_ready;
  logic [2:0] instr_op;
  logic [AREG_W-1:0] instr_rd;
  logic [AREG_W-1:0] instr_rs1;
  logic [AREG_W-1:0] instr_rs2;
  logic [DATA_W-1:0] instr_imm;
  logic [2:0] alu_mode;
  logic [DATA_W-1:0] alu_reg1;
  logic [DATA_W-1:0] alu_reg2;
  logic [DATA_W-1:0] alu_out;
  logic done;
  logic flag_z;
  logic flag_n;
  modport slave (
    input instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, alu_out,
    output instr_ready, alu_mode, alu_reg1, alu_reg2, done, flag_z, flag_n
  );
  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs1, instr_rs2, instr_imm, alu_out,
    input instr_ready, alu_mode, alu_reg1, alu_reg2, done, flag_z, flag_n
  );
endinterface

// File: rtl/cpu_regfile.sv
// cpu_regfile: NREG x DATA_W register file, two async read ports, debug read, one sync write
module cpu_regfile
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AREG_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AREG_W-1:0] raddr_a,
  input  logic [AREG_W-1:0] raddr_b,
  input  logic [AREG_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] rdata_a,
  output logic [DATA_W-1:0] rdata_b,
  output logic [DATA_W-1:0] dbg_data
);
  logic [DATA_W-1:0] rf_q [NREG];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 0; i < NREG; i++) rf_q[i] <= '0;
    else if (we) rf_q[waddr] <= wdata;
  assign rdata_a = rf_q[raddr_a];
  assign rdata_b = rf_q[raddr_b];
  assign dbg_data = rf_q[dbg_addr];
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: non-pipelined IDLE/EXEC/WB sequencer feeding an external ALU and writing
// its result back to the local register file, one instruction per three cycles
module alu_exec_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  alu_exec_ctrl_if.slave    bus,
  input  logic [AREG_W-1:0] dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);
  state_e state_q, state_d;
  logic [2:0] op_q, alu_mode_q;
  logic [AREG_W-1:0] rd_q;
  logic [DATA_W-1:0] imm_q, reg1_q, reg2_q, result_q, rd1, rd2;
  logic done_q, z_q, n_q, we, accept;
  assign accept = state_q == IDLE && bus.instr_valid;
  assign we = state_q == WB && op_q != OP_NOP;
  always_comb begin
    state_d = state_q == IDLE ? (bus.instr_valid ? EXEC : IDLE) : state_q == EXEC ? WB : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      op_q <= '0;
      rd_q <= '0;
      imm_q <= '0;
      alu_mode_q <= '0;
      reg1_q <= '0;
      reg2_q <= '0;
      result_q <= '0;
      done_q <= 1'b0;
      z_q <= 1'b0;
      n_q <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q <= state_q == WB;
      if (accept) begin
        op_q <= bus.instr_op;
        rd_q <= bus.instr_rd;
        imm_q <= bus.instr_imm;
        alu_mode_q <= bus.instr_op;
        reg1_q <= rd1;
        reg2_q <= rd2;
      end
      // LOADI bypasses the ALU, which returns 0 for modes 6/7
      if (state_q == EXEC) result_q <= op_q == OP_LOADI ? imm_q : bus.alu_out;
      if (we) begin
        z_q <= result_q == '0;
        n_q <= result_q[DATA_W-1];
      end
    end
  cpu_regfile u_rf (
    .clk(clk), .rst_n(rst_n), .we(we), .waddr(rd_q), .wdata(result_q),
    .raddr_a(bus.instr_rs1), .raddr_b(bus.instr_rs2), .dbg_addr(dbg_addr),
    .rdata_a(rd1), .rdata_b(rd2), .dbg_data(dbg_data)
  );
  assign bus.instr_ready = state_q == IDLE;
  assign bus.alu_mode = alu_mode_q;
  assign bus.alu_reg1 = reg1_q;
  assign bus.alu_reg2 = reg2_q;
  assign bus.done = done_q;
  assign bus.flag_z = z_q;
  assign bus.flag_n = n_q;
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// tb_alu_exec_ctrl: directed sequence with a behavioural ALU and an expected-writeback queue
module tb_alu_exec_ctrl;
  import cpu_pkg::*;
  typedef struct {logic [2:0] rd; logic [7:0] val; logic z; logic n;} exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] dbg_addr = '0;
  logic [7:0] dbg_data;
  int errors = 0;
  int checks = 0;
  logic [7:0] m_rf [8];
  logic mz = 1'b0, mn = 1'b0;
  exp_t sb [$];
  alu_exec_ctrl_if ifc ();
  alu_exec_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc), .dbg_addr(dbg_addr), .dbg_data(dbg_data));
  always #5 clk = ~clk;
  always_comb begin
    ifc.alu_out = 8'h00;
    case (ifc.alu_mode)
      3'd0: ifc.alu_out = ifc.alu_reg1 + ifc.alu_reg2;
      3'd1: ifc.alu_out = ifc.alu_reg1 - ifc.alu_reg2;
      3'd2: ifc.alu_out = ifc.alu_reg1 & ifc.alu_reg2;
      3'd3: ifc.alu_out = ifc.alu_reg1 | ifc.alu_reg2;
      3'd4: ifc.alu_out = ~ifc.alu_reg1;
      3'd5: ifc.alu_out = ifc.alu_reg1 ^ ifc.alu_reg2;
      default: ifc.alu_out = 8'h00;
    endcase
  end
  function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] a, b, imm);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return ~a;
      3'd5: return a ^ b;
      3'd6: return imm;
      default: return 8'h00;
    endcase
  endfunction
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic check_reg(input logic [2:0] r, input logic [7:0] exp);
    dbg_addr = r;
    #1;
    chk($sformatf("rf[%0d]", r), dbg_data, exp);
  endtask
  task automatic issue(input logic [2:0] op, rd, rs1, rs2, input logic [7:0] imm, input bit keep);
    int w = 0;
    logic [7:0] a, b, r;
    exp_t e;
    while (!ifc.instr_ready && w < 20) begin @(negedge clk); w++; end
    chk("ready_idle", ifc.instr_ready, 1);
    a = m_rf[rs1];
    b = m_rf[rs2];
    r = model(op, a, b, imm);
    if (op != OP_NOP) begin m_rf[rd] = r; mz = r == 0; mn = r[7]; end
    sb.push_back('{rd, m_rf[rd], mz, mn});
    ifc.instr_op = op; ifc.instr_rd = rd; ifc.instr_rs1 = rs1; ifc.instr_rs2 = rs2; ifc.instr_imm = imm;
    ifc.instr_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("exec_mode", ifc.alu_mode, op);
    chk("exec_reg1", ifc.alu_reg1, a);
    chk("exec_reg2", ifc.alu_reg2, b);
    chk("exec_ready", ifc.instr_ready, 0);
    chk("exec_done", ifc.done, 0);
    @(negedge clk);
    chk("wb_ready", ifc.instr_ready, 0);
    chk("wb_done", ifc.done, 0);
    @(negedge clk);
    chk("retire_done", ifc.done, 1);
    chk("retire_ready", ifc.instr_ready, 1);
    if (!keep) ifc.instr_valid = 1'b0;
    e = sb.pop_front();
    check_reg(e.rd, e.val);
    chk("flag_z", ifc.flag_z, e.z);
    chk("flag_n", ifc.flag_n, e.n);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
    ifc.instr_valid = 1'b0; ifc.instr_op = '0; ifc.instr_rd = '0;
    ifc.instr_rs1 = '0; ifc.instr_rs2 = '0; ifc.instr_imm = '0;
    repeat (2) @(negedge clk);
    chk("rst_ready", ifc.instr_ready, 1);
    chk("rst_done", ifc.done, 0);
    chk("rst_mode", ifc.alu_mode, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_flag_z", ifc.flag_z, 0);
    chk("rst_flag_n", ifc.flag_n, 0);
    check_reg(3'd5, 8'h00);
    issue(OP_LOADI, 3'd1, 3'd0, 3'd0, 8'h0F, 0);
    issue(OP_LOADI, 3'd2, 3'd0, 3'd0, 8'hF0, 0);
    chk("r2_flag_n", ifc.flag_n, 1);
    issue(OP_ADD, 3'd3, 3'd1, 3'd2, 8'h00, 0);
    issue(OP_SUB, 3'd4, 3'd1, 3'd1, 8'h00, 0);
    issue(OP_ADD, 3'd5, 3'd3, 3'd1, 8'h00, 0);
    check_reg(3'd5, 8'h0E);
    issue(OP_NOT, 3'd1, 3'd2, 3'd2, 8'h00, 0);
    issue(OP_XOR, 3'd6, 3'd1, 3'd2, 8'h00, 0);
    check_reg(3'd6, 8'hFF);
    issue(OP_NOP, 3'd3, 3'd1, 3'd2, 8'h55, 0);
    issue(OP_OR, 3'd0, 3'd1, 3'd2, 8'h00, 1);
    issue(OP_AND, 3'd0, 3'd1, 3'd2, 8'h00, 1);
    issue(OP_SUB, 3'd0, 3'd2, 3'd1, 8'h00, 0);
    @(negedge clk);
    chk("hold_ready", ifc.instr_ready, 1);
    chk("hold_done", ifc.done, 0);
    check_reg(3'd0, 8'hE1);
    @(negedge clk);
    ifc.instr_op = OP_ADD; ifc.instr_rd = 3'd7; ifc.instr_rs1 = 3'd1; ifc.instr_rs2 = 3'd2;
    ifc.instr_valid = 1'b1;
    @(posedge clk);
    #1 ifc.instr_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_ready", ifc.instr_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("arst_ready", ifc.instr_ready, 1);
    chk("arst_done", ifc.done, 0);
    chk("arst_reg1", ifc.alu_reg1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("post_rst_done", ifc.done, 0);
      chk("post_rst_ready", ifc.instr_ready, 1);
    end
    chk("post_rst_z", ifc.flag_z, 0);
    chk("post_rst_n", ifc.flag_n, 0);
    for (int i = 0; i < 8; i++) begin
      check_reg(i[2:0], 8'h00);
      m_rf[i] = 8'h00;
    end
    mz = 1'b0; mn = 1'b0;
    issue(OP_LOADI, 3'd7, 3'd0, 3'd0, 8'h80, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
- Execute/writeback sequencer that sits directly upstream and downstream of the 8-bit ALU.
- Accepts one decoded instruction per valid/ready handshake and reads two operands from an internal 8x8 register file.
- Drives the ALU's mode/reg1/reg2 inputs, captures the ALU's combinational result, and writes it back to the register file.
- Updates zero/negative flags and pulses done when the instruction retires; sequencing is multi-cycle and non-pipelined.

Parameters:
- DATA_W, 8, datapath width; must match the ALU.
- NREG, 8, number of register-file entries.
- AREG_W, 3, register index width (log2 NREG).

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- instr_valid  in  1  decoded instruction present.
- instr_ready  out  1  block can accept an instruction; equals (state==IDLE).
- instr_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 NOT, 5 XOR, 6 LOADI, 7 NOP.
- instr_rd  in  3  destination register.
- instr_rs1  in  3  source 1; drives ALU reg1.
- instr_rs2  in  3  source 2; drives ALU reg2.
- instr_imm  in  8  immediate for LOADI.
- alu_mode  out  3  to ALU mode.
- alu_reg1  out  8  to ALU reg1.
- alu_reg2  out  8  to ALU reg2.
- alu_out  in  8  combinational ALU result.
- done  out  1  one-cycle retire pulse.
- flag_z  out  1  last written result == 0.
- flag_n  out  1  last written result bit 7.
- dbg_addr  in  3  debug read index.
- dbg_data  out  8  combinational rf[dbg_addr].

Behaviour:
- Reset (async, rst_n=0):
  - state = IDLE.
  - All RF entries = 0x00.
  - alu_mode, alu_reg1, alu_reg2, result_q = 0.
  - done = 0, flag_z = 0, flag_n = 0.
  - Reset dominates any handshake; instr_ready reads 1 but nothing is accepted while rst_n=0.
  - Reset mid-instruction abandons it: no writeback, no done.
- FSM states: IDLE -> EXEC -> WB -> IDLE, one cycle each except IDLE.
- IDLE:
  - instr_ready = 1.
  - On an edge with instr_valid=1: latch op, rd and imm; alu_mode <= op; alu_reg1 <= rf[rs1]; alu_reg2 <= rf[rs2]; go to EXEC.
  - Otherwise stay in IDLE; ALU outputs hold their last values.
- EXEC:
  - instr_ready = 0; ALU inputs stable for the whole cycle.
  - result_q <= (op==LOADI) ? imm : alu_out; go to WB.
- WB:
  - Op != NOP: rf[rd] <= result_q, flag_z <= (result_q==0), flag_n <= result_q[7].
  - Op == NOP: no RF write, flags hold.
  - done <= 1 (registered, high for exactly the cycle after the WB edge); go to IDLE.
- Timing:
  - Handshake at edge E0: operands valid after E0, result_q after E1, RF/flags/done after E2.
  - Next accept possible at E3; throughput 1 instruction per 3 cycles.
- Hazards: none. A source read in IDLE always sees a prior instruction's writeback, since WB completes before IDLE.
- rd == rs1/rs2 is legal: the old value is read, the new value is written.
- Ops 6/7 drive alu_mode 6/7; the ALU returns 0 and the block ignores it.
- Arithmetic wraps modulo 256; there is no carry flag.
- instr_valid while not ready is ignored; the upstream block must hold it.
- done is cleared on every edge where it is not being set.
- dbg_data is combinational and reflects a WB write after that edge.

Decomposition:
- Shared package cpu_pkg holds:
  - DATA_W, AREG_W.
  - Opcode constants OP_ADD..OP_XOR, OP_LOADI, OP_NOP (values 0-7, consistent with the ALU's mode encoding).
  - FSM state enum {IDLE, EXEC, WB}.
- Sub-module cpu_regfile: NREG x DATA_W with async reset, two combinational read ports plus a debug read port, and one synchronous write port (we, waddr, wdata).
- alu_exec_ctrl instantiates cpu_regfile; the ALU itself is instantiated alongside it at the next level up.

Test Plan:
- Reset then LOADI r1=0x0F, then LOADI r2=0xF0 -> dbg r1=0x0F, r2=0xF0; done pulses once per instruction, 3 cycles apart; flag_n=1 after r2.
- ADD r3=r1+r2 -> during EXEC alu_mode=0, alu_reg1=0x0F, alu_reg2=0xF0; r3=0xFF, flag_z=0, flag_n=1.
- SUB r4=r1-r1 -> r4=0x00, flag_z=1, flag_n=0; then ADD r5=r3+r1 -> r5=0x0E (wrap), flag_z=0.
- NOT r1=r2 (rd==... r1 overwritten) then XOR r6=r1^r2 -> r1=0x0F, r6=0xFF; NOP -> done pulses, no RF change, flags unchanged.
- Hold instr_valid high continuously -> instr_ready low in EXEC/WB, exactly one accept per 3 cycles, no instruction dropped or duplicated.
- Pulse rst_n low during EXEC of ADD r7 -> r7 stays 0x00, no done, all RF and flags 0, state IDLE, ready=1 after release.
